// File: rtl/regfile_write_scheduler_if.sv
// regfile_write_scheduler_if: writeback requester handshakes plus register-file write port bundle
interface regfile_write_scheduler_if #(
  parameter int XLEN = 64,
  parameter int RW = 5
);
  logic            req0_valid;
  logic [RW-1:0]   req0_rd;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [RW-1:0]   req1_rd;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;
  logic            rf_reg_write;
  logic [RW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_write_data;
  logic            init_done;
  logic [15:0]     stall_cnt;
  modport master (
    output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready, rf_reg_write, rf_rd, rf_write_data, init_done, stall_cnt
  );
  modport slave (
    input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready, rf_reg_write, rf_rd, rf_write_data, init_done, stall_cnt
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: init sweep then round-robin sharing of the register-file write port
module regfile_write_scheduler #(
  parameter int              XLEN        = 64,
  parameter int              NUM_REGS    = 32,
  parameter logic [XLEN-1:0] INIT_VALUE  = '0,
  parameter bit              INIT_ENABLE = 1'b1
) (
  input logic clk,
  input logic reset,
  regfile_write_scheduler_if.slave bus
);
  localparam int RW = $clog2(NUM_REGS);
  typedef enum logic {INIT, RUN} state_t;
  state_t          r_state;
  logic [RW-1:0]   r_init_cnt;
  logic            r_last_grant;
  logic [15:0]     r_stall_cnt;
  logic            r_reg_write;
  logic [RW-1:0]   r_rd;
  logic [XLEN-1:0] r_data;
  logic            r_init_done;
  logic            w_run;
  logic            w_rdy0;
  logic            w_rdy1;
  logic            w_acc;
  logic            w_stall;
  logic [RW-1:0]   w_acc_rd;
  logic [XLEN-1:0] w_acc_data;
  // last_grant==1 means req1 was served last, so req0 wins the next tie
  always_comb begin
    w_run      = r_state == RUN;
    w_rdy0     = w_run & bus.req0_valid & (~bus.req1_valid | r_last_grant);
    w_rdy1     = w_run & bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    w_acc      = w_rdy0 | w_rdy1;
    w_acc_rd   = w_rdy1 ? bus.req1_rd : bus.req0_rd;
    w_acc_data = w_rdy1 ? bus.req1_data : bus.req0_data;
    w_stall    = w_run & ((bus.req0_valid & ~w_rdy0) | (bus.req1_valid & ~w_rdy1));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= INIT_ENABLE ? INIT : RUN;
      r_init_cnt   <= RW'(1);
      r_last_grant <= 1'b1;
      r_stall_cnt  <= '0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_data       <= '0;
      r_init_done  <= ~INIT_ENABLE;
    end else if (r_state == INIT) begin
      r_reg_write <= 1'b1;
      r_rd        <= r_init_cnt;
      r_data      <= INIT_VALUE;
      r_init_cnt  <= r_init_cnt + RW'(1);
      if (r_init_cnt == RW'(NUM_REGS - 1)) begin
        r_state     <= RUN;
        r_init_done <= 1'b1;
      end
    end else begin
      r_reg_write <= w_acc & (w_acc_rd != '0);
      if (w_acc) begin
        r_rd         <= w_acc_rd;
        r_data       <= w_acc_data;
        r_last_grant <= w_rdy1;
      end
      if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
  assign bus.req0_ready    = w_rdy0;
  assign bus.req1_ready    = w_rdy1;
  assign bus.rf_reg_write  = r_reg_write;
  assign bus.rf_rd         = r_rd;
  assign bus.rf_write_data = r_data;
  assign bus.init_done     = r_init_done;
  assign bus.stall_cnt     = r_stall_cnt;
endmodule
